seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux_if.sv | 30 +++
 rtl/seg_scan_mux.sv | 102 ++++++++++
 tb/tb_seg_scan_mux.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// rtl/seg_scan_mux_if.sv - bus bundle between the display scanner and its driver
// Purpose: groups the load/config inputs and the digit/anode outputs of seg_scan_mux.
// Signals:
//   Load, DataIn[15:0]   value capture into the pending register
//   BlankMask[3:0], LZB  live per-digit blanking controls
//   Out3..Out0           nibble of the active digit (decoder In3..In0)
//   An[3:0]              active-low one-hot anode enables
//   FrameDone            one-cycle pulse after each frame boundary
interface seg_scan_mux_if;
    logic        Load;
    logic [15:0] DataIn;
    logic [3:0]  BlankMask;
    logic        LZB;
    logic        Out3;
    logic        Out2;
    logic        Out1;
    logic        Out0;
    logic [3:0]  An;
    logic        FrameDone;

    modport master (
        output Load, DataIn, BlankMask, LZB,
        input  Out3, Out2, Out1, Out0, An, FrameDone
    );

    modport slave (
        input  Load, DataIn, BlankMask, LZB,
        output Out3, Out2, Out1, Out0, An, FrameDone
    );
endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - four-digit time-multiplexed 7-segment scanner
// Purpose: steps through the four nibbles of a double-buffered 16-bit value at
//          REFRESH_DIV clocks per digit, with per-digit masking and leading-zero blanking.
// Ports:
//   Clk    system clock, rising edge
//   Reset  asynchronous active-high reset
//   bus    seg_scan_mux_if.slave (Load/DataIn/BlankMask/LZB in; Out3..Out0/An/FrameDone out)
module seg_scan_mux #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic           Clk,
    input  logic           Reset,
    seg_scan_mux_if.slave  bus
);
    localparam int PW = (REFRESH_DIV <= 2) ? 1 : $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   value_q, value_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_valid_q, pend_valid_d;
    logic [3:0]    nib_q, nib_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          tick;
    logic          boundary;
    logic [3:0]    lzb_blank;
    logic [3:0]    nib_sel;
    logic          dark;

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        boundary = tick && (idx_q == 2'd3);

        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_d   = tick ? idx_q + 2'd1 : idx_q;

        // Commit uses the pending value from before this edge, so a Load on
        // the boundary edge only becomes the pending value for the next frame.
        value_d = (boundary && pend_valid_q) ? pend_q : value_q;

        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (bus.Load) begin
            pend_d       = bus.DataIn;
            pend_valid_d = 1'b1;
        end else if (boundary) begin
            pend_valid_d = 1'b0;
        end

        // Blanking chains down from the top digit; digit 0 always shows.
        lzb_blank[3] = bus.LZB && (value_d[15:12] == 4'h0);
        lzb_blank[2] = lzb_blank[3] && (value_d[11:8] == 4'h0);
        lzb_blank[1] = lzb_blank[2] && (value_d[7:4] == 4'h0);
        lzb_blank[0] = 1'b0;

        case (idx_d)
            2'd0:    nib_sel = value_d[3:0];
            2'd1:    nib_sel = value_d[7:4];
            2'd2:    nib_sel = value_d[11:8];
            default: nib_sel = value_d[15:12];
        endcase

        dark = bus.BlankMask[idx_d] | lzb_blank[idx_d];

        nib_d = tick ? nib_sel : nib_q;
        an_d  = an_q;
        if (tick) begin
            an_d = dark ? 4'b1111 : ~(4'b0001 << idx_d);
        end

        fd_d = boundary;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q      <= '0;
            idx_q        <= 2'd3;
            value_q      <= 16'h0000;
            pend_q       <= 16'h0000;
            pend_valid_q <= 1'b0;
            nib_q        <= 4'h0;
            an_q         <= 4'b1111;
            fd_q         <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            value_q      <= value_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            fd_q         <= fd_d;
        end
    end

    assign {bus.Out3, bus.Out2, bus.Out1, bus.Out0} = nib_q;
    assign bus.An        = an_q;
    assign bus.FrameDone = fd_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb/tb_seg_scan_mux.sv - self-checking bench for seg_scan_mux
module tb_seg_scan_mux;
    localparam int DIV = 4;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    seg_scan_mux_if bus ();

    seg_scan_mux #(.REFRESH_DIV(DIV)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0] an;
        logic [3:0] out;
        logic       fd;
    } exp_t;

    // an is {slot3,slot2,slot1,slot0}; the displayed nibbles equal data itself
    typedef struct {
        logic [15:0] data;
        logic        lzb;
        logic [3:0]  mask;
        logic [15:0] an;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] an, input logic [15:0] out);
        for (int s = 0; s < 4; s++) begin
            exp_t e;
            e.an  = an[s*4 +: 4];
            e.out = out[s*4 +: 4];
            e.fd  = (s == 0);
            sb.push_back(e);
        end
    endtask

    task automatic check_slot(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=none exp=entry", name);
        end else begin
            e = sb.pop_front();
            chk({name, " An"}, bus.An, e.an);
            chk({name, " Out"}, {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, e.out);
            chk({name, " FrameDone"}, {3'b000, bus.FrameDone}, {3'b000, e.fd});
        end
    endtask

    // Call positioned just after a frame-boundary edge; returns just after slot 3.
    task automatic check_frame(input string name);
        check_slot($sformatf("%s s0", name));
        for (int s = 1; s < 4; s++) begin
            step(DIV);
            check_slot($sformatf("%s s%0d", name, s));
        end
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h0050, 1'b1, 4'b0000, 16'hFFDE};
        vecs[1] = '{16'h0000, 1'b1, 4'b0000, 16'hFFFE};
        vecs[2] = '{16'hFFFF, 1'b0, 4'b0101, 16'h7FDF};
        vecs[3] = '{16'h8001, 1'b1, 4'b0000, 16'h7BDE};
        vecs[4] = '{16'h0300, 1'b1, 4'b1000, 16'hFBDE};
        vecs[5] = '{16'hC0DE, 1'b0, 4'b0000, 16'h7BDE};

        Reset         = 1'b1;
        bus.Load      = 1'b0;
        bus.DataIn    = 16'h0000;
        bus.BlankMask = 4'b0000;
        bus.LZB       = 1'b0;
        step(2);
        chk("reset An", bus.An, 4'b1111);
        chk("reset Out", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 4'b0000);
        chk("reset FrameDone", {3'b000, bus.FrameDone}, 4'b0000);

        // Release, then Load 1234 one cycle later; first Tick at edge 4
        Reset = 1'b0;
        step(1);
        bus.Load   = 1'b1;
        bus.DataIn = 16'h1234;
        push_frame(16'h7BDE, 16'h1234);
        step(1);
        bus.Load = 1'b0;
        step(1);
        chk("no early tick An", bus.An, 4'b1111);
        step(1);
        check_frame("first");

        // Table: load during slot 3, checked over the next frame
        for (int i = 0; i < 6; i++) begin
            bus.Load      = 1'b1;
            bus.DataIn    = vecs[i].data;
            bus.LZB       = vecs[i].lzb;
            bus.BlankMask = vecs[i].mask;
            push_frame(vecs[i].an, vecs[i].data);
            step(1);
            bus.Load = 1'b0;
            step(DIV - 1);
            check_frame($sformatf("vec%0d", i));
        end
        bus.LZB       = 1'b0;
        bus.BlankMask = 4'b0000;

        // Two loads in one frame: last write wins
        bus.Load   = 1'b1;
        bus.DataIn = 16'hAAAA;
        step(1);
        bus.DataIn = 16'h5555;
        push_frame(16'h7BDE, 16'h5555);
        step(1);
        bus.Load = 1'b0;
        step(DIV - 2);
        check_frame("twoload");
        push_frame(16'h7BDE, 16'h5555);
        step(DIV);
        check_frame("twoload hold");

        // Load BEEF on the boundary edge while 1111 is pending
        bus.Load   = 1'b1;
        bus.DataIn = 16'h1111;
        step(1);
        bus.Load = 1'b0;
        step(DIV - 2);
        bus.Load   = 1'b1;
        bus.DataIn = 16'hBEEF;
        push_frame(16'h7BDE, 16'h1111);
        step(1);
        bus.Load = 1'b0;
        check_frame("edgeload old");
        push_frame(16'h7BDE, 16'hBEEF);
        step(DIV);
        check_frame("edgeload new");

        // Reset during slot 2 with 7777 pending
        step(DIV);
        step(DIV);
        bus.Load   = 1'b1;
        bus.DataIn = 16'h7777;
        step(1);
        bus.Load = 1'b0;
        step(DIV - 1);
        step(1);
        chk("pre-reset An", bus.An, 4'b1011);
        chk("pre-reset Out", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 4'hE);
        Reset = 1'b1;
        #1;
        chk("async reset An", bus.An, 4'b1111);
        chk("async reset Out", {bus.Out3, bus.Out2, bus.Out1, bus.Out0}, 4'b0000);
        chk("async reset FrameDone", {3'b000, bus.FrameDone}, 4'b0000);
        step(1);
        Reset = 1'b0;
        step(DIV - 1);
        chk("post-reset no early tick", bus.An, 4'b1111);
        push_frame(16'h7BDE, 16'h0000);
        step(1);
        check_frame("post-reset");

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard leftover got=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
